// File: rtl/mem_arbiter.sv
// Two-master, one-slave round-robin arbiter for the valid/ready memory bus.
// The grant is held until the slave acknowledges or the watchdog expires.
module mem_arbiter #(
  parameter int          TIMEOUT      = 1024,
  parameter logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        timeout_err,
  output logic [31:0] err_addr
);

  localparam int WDOG_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST = (TIMEOUT > 0) ? WDOG_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t            state_reg, state_next;
  logic              last_reg, last_next;
  logic [WDOG_W-1:0] wdog_reg, wdog_next;
  logic              timeout_err_reg, timeout_err_next;
  logic [31:0]       err_addr_reg, err_addr_next;

  logic              sel1;
  logic              timeout_hit;
  logic              done;
  logic [31:0]       gnt_addr, gnt_wdata, rsp_rdata;
  logic [3:0]        gnt_wstrb;

  assign sel1      = (state_reg == GNT1);
  assign gnt_addr  = sel1 ? m1_addr  : m0_addr;
  assign gnt_wdata = sel1 ? m1_wdata : m0_wdata;
  assign gnt_wstrb = sel1 ? m1_wstrb : m0_wstrb;

  // A coinciding mem_ready takes priority over the watchdog.
  assign timeout_hit = (TIMEOUT > 0) && (state_reg != IDLE) && !mem_ready &&
                       (wdog_reg == WDOG_LAST);
  assign done        = mem_ready || timeout_hit;
  assign rsp_rdata   = timeout_hit ? TIMEOUT_DATA : mem_rdata;

  always_comb begin
    state_next       = state_reg;
    last_next        = last_reg;
    wdog_next        = wdog_reg;
    timeout_err_next = 1'b0;
    err_addr_next    = err_addr_reg;
    mem_valid        = 1'b0;
    mem_addr         = '0;
    mem_wdata        = '0;
    mem_wstrb        = '0;
    m0_ready         = 1'b0;
    m1_ready         = 1'b0;
    m0_rdata         = '0;
    m1_rdata         = '0;
    case (state_reg)
      IDLE: begin
        // On a tie, last_reg==1 means master 0 is owed the bus.
        if (m0_valid && (!m1_valid || last_reg)) begin
          state_next = GNT0;
          last_next  = 1'b0;
          wdog_next  = '0;
        end else if (m1_valid) begin
          state_next = GNT1;
          last_next  = 1'b1;
          wdog_next  = '0;
        end
      end
      GNT0, GNT1: begin
        mem_valid = 1'b1;
        mem_addr  = gnt_addr;
        mem_wdata = gnt_wdata;
        mem_wstrb = gnt_wstrb;
        if (sel1) begin
          m1_ready = done;
          m1_rdata = rsp_rdata;
        end else begin
          m0_ready = done;
          m0_rdata = rsp_rdata;
        end
        if (done) begin
          state_next = IDLE;
        end
        if (timeout_hit) begin
          timeout_err_next = 1'b1;
          err_addr_next    = gnt_addr;
        end
        if ((TIMEOUT > 0) && !mem_ready) begin
          wdog_next = wdog_reg + WDOG_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg       <= IDLE;
      last_reg        <= 1'b1;
      wdog_reg        <= '0;
      timeout_err_reg <= 1'b0;
      err_addr_reg    <= '0;
    end else begin
      state_reg       <= state_next;
      last_reg        <= last_next;
      wdog_reg        <= wdog_next;
      timeout_err_reg <= timeout_err_next;
      err_addr_reg    <= err_addr_next;
    end
  end

  assign timeout_err = timeout_err_reg;
  assign err_addr    = err_addr_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected grants and responses are queued
// by the stimulus and retired by a negedge monitor that also models the slave.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        m0_valid, m1_valid, m0_ready, m1_ready;
  logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        mem_valid, mem_ready, timeout_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, err_addr;
  logic [3:0]  mem_wstrb;

  mem_arbiter #(.TIMEOUT(8), .TIMEOUT_DATA(32'hDEADBEEF)) dut (
    .clk(clk), .rstn(rstn),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .timeout_err(timeout_err), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb;} req_t;
  typedef struct {int m; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb;} gnt_t;
  typedef struct {int m; logic [31:0] rdata; int len; bit tmo; logic [31:0] addr;} rsp_t;

  req_t m0q[$], m1q[$];
  gnt_t exp_gnt[$];
  rsp_t exp_rsp[$];

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          gcnt = 0;
  int          slv_lat = 1;
  logic [31:0] slv_rdata = '0;
  int          gnt_start = 0;
  int          last_done = -1;
  int          present_cyc[2];
  bit          gap_chk = 0;
  bit          lat_chk = 0;
  bit          prev_valid = 0;
  bit          terr_exp = 0;
  logic [31:0] terr_addr = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive(input int m, input req_t r, input bit v);
    if (m == 0) begin
      m0_valid = v; m0_addr = r.addr; m0_wdata = r.wdata; m0_wstrb = r.wstrb;
    end else begin
      m1_valid = v; m1_addr = r.addr; m1_wdata = r.wdata; m1_wstrb = r.wstrb;
    end
  endtask

  task automatic req(input int m, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    req_t r;
    gnt_t g;
    r.addr = a; r.wdata = d; r.wstrb = s;
    g.m = m; g.addr = a; g.wdata = d; g.wstrb = s;
    if (m == 0) m0q.push_back(r); else m1q.push_back(r);
    exp_gnt.push_back(g);
  endtask

  task automatic expect_rsp(input int m, input logic [31:0] d, input int len, input bit tmo,
                            input logic [31:0] a);
    rsp_t r;
    r.m = m; r.rdata = d; r.len = len; r.tmo = tmo; r.addr = a;
    exp_rsp.push_back(r);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((exp_gnt.size() != 0 || exp_rsp.size() != 0 || m0q.size() != 0 ||
            m1q.size() != 0 || m0_valid || m1_valid) && n < budget) begin
      @(negedge clk); #2;
      n++;
    end
    if (n >= budget) begin
      check_eq("wait_idle_budget", 64'd0, 64'd1);
      exp_gnt.delete(); exp_rsp.delete(); m0q.delete(); m1q.delete();
      m0_valid = 1'b0; m1_valid = 1'b0;
    end
  endtask

  // Slave model, master drivers and scoreboard retirement.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (mem_valid) gcnt++; else gcnt = 0;
      mem_ready = mem_valid && (slv_lat != 0) && (gcnt == slv_lat);
      mem_rdata = mem_ready ? slv_rdata : 32'h0;
      #1;
      if (rstn) begin
        check_eq("timeout_err", {63'd0, timeout_err}, {63'd0, terr_exp});
        if (terr_exp) check_eq("err_addr", {32'd0, err_addr}, {32'd0, terr_addr});
        terr_exp = 0;
        if (!mem_valid)
          check_eq("idle_bus", {32'd0, mem_addr | mem_wdata | {28'd0, mem_wstrb}}, 64'd0);
        if (mem_valid && !prev_valid) begin
          if (exp_gnt.size() == 0) begin
            check_eq("unexp_grant", {32'd0, mem_addr}, 64'd0);
          end else begin
            gnt_t g;
            g = exp_gnt.pop_front();
            $display("grant m%0d addr=%08h wdata=%08h wstrb=%04b @%0d",
                     g.m, mem_addr, mem_wdata, mem_wstrb, cyc);
            check_eq("gnt_addr", {32'd0, mem_addr}, {32'd0, g.addr});
            check_eq("gnt_wdata", {32'd0, mem_wdata}, {32'd0, g.wdata});
            check_eq("gnt_wstrb", {60'd0, mem_wstrb}, {60'd0, g.wstrb});
            if (gap_chk && last_done >= 0) check_eq("gap", 64'(cyc - last_done), 64'd2);
            if (lat_chk) check_eq("latency", 64'(cyc - present_cyc[g.m]), 64'd1);
            gnt_start = cyc;
          end
        end
        if (m0_ready && m1_ready) check_eq("dual_ready", 64'd1, 64'd0);
        for (int m = 0; m < 2; m++) begin
          logic        rdy;
          logic [31:0] rd;
          rdy = (m == 0) ? m0_ready : m1_ready;
          rd  = (m == 0) ? m0_rdata : m1_rdata;
          if (rdy) begin
            if (exp_rsp.size() == 0) begin
              check_eq("unexp_ready", 64'(m), 64'd9);
            end else begin
              rsp_t r;
              r = exp_rsp.pop_front();
              $display("ready m%0d rdata=%08h len=%0d @%0d", m, rd, cyc - gnt_start + 1, cyc);
              check_eq("rsp_master", 64'(m), 64'(r.m));
              check_eq("rsp_rdata", {32'd0, rd}, {32'd0, r.rdata});
              check_eq("rsp_len", 64'(cyc - gnt_start + 1), 64'(r.len));
              if (r.tmo) begin
                terr_exp  = 1;
                terr_addr = r.addr;
              end
              last_done = cyc;
            end
          end else begin
            check_eq("rdata_idle", {32'd0, rd}, 64'd0);
          end
          if (m == 0) begin
            if (rdy) begin
              if (m0q.size() != 0) begin drive(0, m0q.pop_front(), 1'b1); present_cyc[0] = cyc; end
              else m0_valid = 1'b0;
            end else if (!m0_valid && m0q.size() != 0) begin
              drive(0, m0q.pop_front(), 1'b1); present_cyc[0] = cyc;
            end
          end else begin
            if (rdy) begin
              if (m1q.size() != 0) begin drive(1, m1q.pop_front(), 1'b1); present_cyc[1] = cyc; end
              else m1_valid = 1'b0;
            end else if (!m1_valid && m1q.size() != 0) begin
              drive(1, m1q.pop_front(), 1'b1); present_cyc[1] = cyc;
            end
          end
        end
      end
      prev_valid = mem_valid;
    end
  end

  initial begin
    req_t z;
    int   n;
    z.addr = '0; z.wdata = '0; z.wstrb = '0;
    rstn = 1'b0;
    drive(0, z, 1'b0);
    drive(1, z, 1'b0);
    mem_ready = 1'b0;
    mem_rdata = '0;
    repeat (3) @(negedge clk);
    #2;
    check_eq("rst_mem_valid", {63'd0, mem_valid}, 64'd0);
    check_eq("rst_ready", {62'd0, m0_ready, m1_ready}, 64'd0);
    check_eq("rst_timeout_err", {63'd0, timeout_err}, 64'd0);
    check_eq("rst_err_addr", {32'd0, err_addr}, 64'd0);
    check_eq("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
    @(negedge clk); #3;
    rstn = 1'b1;
    @(negedge clk); #2;

    // Tie after reset: alternation m0, m1, m0, m1 with one bubble between.
    slv_lat = 1; slv_rdata = 32'h1111_2222; last_done = -1; gap_chk = 1;
    req(0, 32'h0000_1000, 32'h0, 4'h0);
    req(1, 32'h0000_2000, 32'h0, 4'h0);
    req(0, 32'h0000_1004, 32'h0, 4'h0);
    req(1, 32'h0000_2004, 32'h0, 4'h0);
    for (int i = 0; i < 4; i++) expect_rsp(i % 2, 32'h1111_2222, 1, 0, 32'h0);
    wait_idle(60);
    gap_chk = 0;

    // Single read with a slow slave.
    slv_lat = 4; slv_rdata = 32'h1234_5678; lat_chk = 1;
    req(0, 32'h0000_0010, 32'h0, 4'h0);
    expect_rsp(0, 32'h1234_5678, 4, 0, 32'h0);
    wait_idle(40);
    lat_chk = 0;

    // m1 write holds the bus while m0 waits.
    slv_lat = 2; slv_rdata = 32'h0;
    req(1, 32'h0300_0004, 32'hCAFE_F00D, 4'b0011);
    expect_rsp(1, 32'h0, 2, 0, 32'h0);
    @(negedge clk); #2;
    req(0, 32'h0000_0040, 32'h0, 4'h0);
    expect_rsp(0, 32'h0, 2, 0, 32'h0);
    wait_idle(40);

    // Watchdog expiry, then m1 served by a responsive slave.
    slv_lat = 0;
    req(0, 32'h0200_0010, 32'h0, 4'h0);
    expect_rsp(0, 32'hDEAD_BEEF, 8, 1, 32'h0200_0010);
    repeat (2) begin @(negedge clk); #2; end
    req(1, 32'h0000_0080, 32'h0, 4'h0);
    expect_rsp(1, 32'h55AA_33CC, 2, 0, 32'h0);
    n = 0;
    while (exp_rsp.size() > 1 && n < 40) begin @(negedge clk); #2; n++; end
    check_eq("timeout_wait", 64'(exp_rsp.size()), 64'd1);
    slv_lat = 2; slv_rdata = 32'h55AA_33CC;
    wait_idle(40);

    // Slave acknowledges on the last watchdog cycle: normal completion.
    slv_lat = 8; slv_rdata = 32'h0BAD_F00D;
    req(0, 32'h0000_0020, 32'h0, 4'h0);
    expect_rsp(0, 32'h0BAD_F00D, 8, 0, 32'h0);
    wait_idle(40);
    check_eq("race_err_addr", {32'd0, err_addr}, {32'd0, 32'h0200_0010});

    // Reset in the middle of an m1 grant: no response must appear.
    slv_lat = 0;
    req(1, 32'h0000_00C0, 32'h0, 4'h0);
    n = 0;
    while (!mem_valid && n < 20) begin @(negedge clk); #2; n++; end
    check_eq("mid_grant_reached", {63'd0, mem_valid}, 64'd1);
    repeat (2) @(negedge clk);
    #3;
    rstn = 1'b0;
    #1;
    check_eq("async_mem_valid", {63'd0, mem_valid}, 64'd0);
    check_eq("async_ready", {62'd0, m0_ready, m1_ready}, 64'd0);
    check_eq("async_err_addr", {32'd0, err_addr}, 64'd0);
    m1_valid = 1'b0;
    m1q.delete();
    exp_gnt.delete();
    repeat (2) @(negedge clk);
    #3;
    rstn = 1'b1;

    // After release m0 wins the first tie again.
    slv_lat = 1; slv_rdata = 32'h7777_0000;
    req(0, 32'h0000_0100, 32'h0, 4'h0);
    req(1, 32'h0000_0104, 32'h0, 4'h0);
    expect_rsp(0, 32'h7777_0000, 1, 0, 32'h0);
    expect_rsp(1, 32'h7777_0000, 1, 0, 32'h0);
    wait_idle(40);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-master, one-slave arbiter for the SoC valid/ready memory bus.
- It shares the single bus that decodes RAM, SPI flash, config registers and iomem between two requesters, e.g. the core and a DMA/debug master.
- Requesters are served round-robin, and the grant is held until the transfer completes.
- A watchdog terminates transfers the slave never acknowledges, and records the failing address.

Parameters:
- TIMEOUT, 1024: max cycles a granted transfer may wait for mem_ready; 0 disables the watchdog.
- TIMEOUT_DATA, 32'hDEADBEEF: rdata returned to the master on a timed-out transfer.

Ports:
- clk  input  1  clock
- rstn  input  1  reset. One clock; reset is asynchronous and active-low.
- m0_valid  input  1  master 0 request; held high until m0_ready.
- m0_ready  output  1  master 0 transfer complete (single-cycle pulse).
- m0_addr  input  32  master 0 address.
- m0_wdata  input  32  master 0 write data.
- m0_wstrb  input  4  master 0 byte strobes; 0 means read.
- m0_rdata  output  32  master 0 read data, valid when m0_ready.
- m1_valid, m1_ready, m1_addr, m1_wdata, m1_wstrb, m1_rdata: as m0, for master 1.
- mem_valid  output  1  slave bus request.
- mem_ready  input  1  slave bus acknowledge.
- mem_addr  output  32  slave address.
- mem_wdata  output  32  slave write data.
- mem_wstrb  output  4  slave byte strobes.
- mem_rdata  input  32  slave read data.
- timeout_err  output  1  one-cycle pulse when a transfer times out.
- err_addr  output  32  address of the most recent timed-out transfer.

Behaviour:
- State machine states: IDLE, GNT0, GNT1. Registers: last (last master granted), wdog counter (width clog2(TIMEOUT+1)).
- Reset values:
  - state=IDLE, last=1 (so m0 wins the first tie), wdog=0.
  - Outputs: mem_valid=0, mem_addr/wdata/wstrb=0, m0_ready=m1_ready=0, m0_rdata=m1_rdata=0, timeout_err=0, err_addr=0.
- Arbitration in IDLE (registered decision):
  - Only m0_valid: next state GNT0.
  - Only m1_valid: next state GNT1.
  - Both valid: grant the master != last.
  - Neither valid: stay in IDLE.
  - On entering GNTx, last<=x and wdog<=0.
- In GNTx (combinational pass-through):
  - mem_valid=1; mem_addr/wdata/wstrb = mx_addr/wdata/wstrb.
  - mx_rdata=mem_rdata; mx_ready=mem_ready.
  - The other master sees ready=0 and rdata=0.
- Outside a grant: mem_addr/wdata/wstrb=0 and mem_valid=0.
- Completion: mem_ready=1 in GNTx → next state IDLE, so one bubble cycle always separates transfers.
  - Latency from mx_valid rising in IDLE to mem_valid is 1 cycle.
  - Minimum total transfer is 2 cycles plus slave latency.
- Watchdog (TIMEOUT>0):
  - In GNTx, while mem_ready=0, wdog increments each cycle.
  - In the cycle where wdog==TIMEOUT-1 and mem_ready=0:
    - mx_ready=1 and mx_rdata=TIMEOUT_DATA.
    - mem_valid still 1 that cycle.
    - err_addr<=mx_addr and timeout_err<=1 (visible next cycle, one cycle only).
    - Next state IDLE.
  - If mem_ready and the timeout coincide, mem_ready wins: normal completion, no error.
  - Writes time out identically; the write is dropped.
- TIMEOUT=0: wdog is held at 0 and a grant waits indefinitely.
- mx_valid dropping during GNTx is a protocol violation. The grant still holds until ready or timeout.
- Asserting rstn low mid-transfer:
  - Immediately forces IDLE, mem_valid=0, all readies 0.
  - err_addr is cleared.
  - No ready pulse is produced for the aborted transfer.
- No combinational path from m*_valid to mem_valid. Paths from mem_ready to m*_ready and from mem_rdata to m*_rdata are combinational.

Test Plan:
- Single read: m0 read at 0x00000010, slave ready 3 cycles after mem_valid with rdata 0x12345678 → mem_valid 1 cycle after m0_valid, m0_ready a 1-cycle pulse with m0_rdata=0x12345678, m1_ready never asserted.
- Simultaneous requests after reset: m0 and m1 both valid, slave 1-cycle ready → order m0, m1, m0, m1, each transfer separated by exactly one idle cycle; mem_addr matches the granted master.
- Write pass-through: m1 writes 0xCAFEF00D with wstrb 4'b0011 to 0x03000004 → mem_wstrb=4'b0011 and mem_wdata=0xCAFEF00D during the grant; m0 is stalled until m1_ready.
- Timeout: TIMEOUT=8, m0 reads 0x02000010, slave never ready → m0_ready on the 8th grant cycle with rdata=0xDEADBEEF, timeout_err pulses next cycle, err_addr=0x02000010, m1 is then served normally.
- Race: TIMEOUT=8, mem_ready first asserted on the 8th grant cycle → normal completion with slave rdata, no timeout_err, err_addr unchanged.
- Reset mid-grant: assert rstn low while in GNT1 → mem_valid=0 and readies 0 asynchronously; after release, m0 wins the first tie (last=1).
